fir_tap_sequencer: RTL and testbench
====================================

# fir_tap_sequencer

Control and MAC datapath for the serial FIR filter. It sits on the read side of the addressable tap delay line (the shift register with `clk`/`clr`/`en`/`add`/`d`/`q`):
- accepts one input sample per handshake;
- sweeps the tap address across the delay line and the coefficient ROM;
- accumulates the signed products;
- shifts the new sample into the delay line;
- presents one saturated output sample per input on a valid/ready port.

## Interface
Parameters:
- `WIDTH_DATA`, 8, input sample and delay-line word width (signed)
- `WIDTH_COEF`, 8, coefficient width (signed)
- `N_TAPS`, 16, filter length; must be a power of two, ≥ 2
- `WIDTH_ACC`, `WIDTH_DATA+WIDTH_COEF+$clog2(N_TAPS)` (20), accumulator width; no internal overflow
- `WIDTH_OUT`, 8, output sample width (signed)
- `OUT_SHIFT`, `WIDTH_COEF-1` (7), right shift applied to the accumulator (Q1.7 coefficients)

Ports:
- `clk`  in  1  single clock, rising edge
- `clr`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  input sample offered
- `in_ready`  out  1  block can accept a sample
- `in_data`  in  WIDTH_DATA  input sample
- `asr_clr`  out  1  delay-line clear
- `asr_en`  out  1  delay-line shift enable
- `asr_add`  out  $clog2(N_TAPS)  delay-line read address
- `asr_d`  out  WIDTH_DATA  delay-line input word
- `asr_q`  in  WIDTH_DATA  delay-line read data, combinational from `asr_add`
- `coef_add`  out  $clog2(N_TAPS)  coefficient ROM address
- `coef`  in  WIDTH_COEF  coefficient ROM data, combinational
- `out_valid`  out  1  output sample valid
- `out_ready`  in  1  downstream accepts output
- `out_data`  out  WIDTH_OUT  filtered output sample

## Operation
States:
- **IDLE:** `in_ready`=1. On `in_valid`&`in_ready`:
  - latch `in_data` into `samp_r`;
  - clear `acc`;
  - set `tap`=0;
  - go to MAC.
- **MAC:** `asr_add`=`coef_add`=`tap`. Each cycle:
  - `acc += $signed(asr_q)*$signed(coef)`;
  - `tap++`;
  - after `tap`=N_TAPS-1, go to SHIFT.
- **SHIFT:** `asr_en`=1 for exactly this cycle, which shifts `samp_r` into the line. `out_data` is registered from the final `acc`. Go to OUT.
- **OUT:** `out_valid`=1, and `out_data` is held stable. On `out_ready`, go to IDLE.

Delay-line and address rules:
- `asr_d`=`samp_r` at all times. Address 0 therefore reads the current sample x[n], and address k reads x[n-k].
- `asr_add`=`coef_add`=0 outside MAC.
- `asr_en`=0 outside SHIFT.
- `in_ready`=0 outside IDLE and while `clr`=1. `in_valid` is ignored outside IDLE.
- `asr_clr` is combinationally equal to `clr`, so the delay line and the controller reset together.

Arithmetic:
- Each product is full-precision WIDTH_DATA+WIDTH_COEF bits, sign-extended to WIDTH_ACC.
- The result is `acc >>> OUT_SHIFT` (arithmetic shift, i.e. floor).
- That result is saturated to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1], i.e. [-128, 127] by default.

Reset:
- While `clr`=1 at a clock edge, the following are zeroed: state=IDLE, `tap`, `acc`, `samp_r`, `out_data`, `out_valid`, `asr_en`.
- Reset during MAC or SHIFT abandons the sample with no `asr_en` pulse. `out_valid` is low from the cycle after the edge.

## Timing
- Acceptance edge E0. MAC occupies the N_TAPS cycles after E0; SHIFT is the next cycle.
- `out_valid` rises N_TAPS+1 cycles after E0 (17 by default).
- With `out_ready` held high and `in_valid` held high, a new sample is accepted every N_TAPS+3 cycles (19 by default).
- `asr_en` pulses exactly once per accepted sample, never while `out_valid`=1.
- `out_data` changes only at the SHIFT→OUT edge and at reset.

## Test plan
Benches model the delay line as 16 registers with address 0 = `d`, and the ROM as a combinational array.
1. **Impulse.** Coefficients c[k]=2(k+1). Feed 64, then 16 zeros, `out_ready`=1.
   - Outputs are 1, 2, …, 16, then 0.
   - Each `out_valid` rises 17 cycles after its acceptance.
2. **Saturation.** All coefficients 127.
   - 16 samples of 127: the 16th output is 127 (raw 258064>>>7=2016).
   - 16 samples of -128: the 16th output is -128 (raw -2032).
3. **Backpressure.** Hold `out_ready`=0 for 5 cycles in OUT while driving `in_valid`=1.
   - `out_valid`/`out_data` stay stable.
   - `in_ready`=0.
   - No second `asr_en`.
   - On release, the next sample is accepted 1 cycle after the handshake.
4. **Throughput.** `in_valid`=`out_ready`=1 for 100 cycles.
   - Acceptances are spaced exactly 19 cycles apart.
   - `asr_add` sweeps 0..15 once per sample.
   - One `asr_en` pulse per sample.
5. **Reset mid-MAC.** Assert `clr` for 1 cycle at `tap`=7.
   - `asr_clr`=1 in that cycle.
   - No `asr_en` pulse follows.
   - State returns to IDLE with `out_valid`=0.
   - A subsequent impulse reproduces the scenario 1 outputs exactly.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_tap_sequencer                                            |
// | Description : Serial FIR control and MAC datapath. Accepts one sample per  |
// |               handshake, sweeps the tap delay line and coefficient ROM,    |
// |               accumulates signed products, shifts the sample into the      |
// |               line, and presents one saturated output per input.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_tap_sequencer #(
  parameter int WIDTH_DATA = 8,
  parameter int WIDTH_COEF = 8,
  parameter int N_TAPS     = 16,
  parameter int WIDTH_ACC  = WIDTH_DATA + WIDTH_COEF + $clog2(N_TAPS),
  parameter int WIDTH_OUT  = 8,
  parameter int OUT_SHIFT  = WIDTH_COEF - 1
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH_DATA-1:0]       in_data,
  output logic                        asr_clr,
  output logic                        asr_en,
  output logic [$clog2(N_TAPS)-1:0]   asr_add,
  output logic [WIDTH_DATA-1:0]       asr_d,
  input  logic [WIDTH_DATA-1:0]       asr_q,
  output logic [$clog2(N_TAPS)-1:0]   coef_add,
  input  logic [WIDTH_COEF-1:0]       coef,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH_OUT-1:0]        out_data
);

  localparam int C_ADDR_W = $clog2(N_TAPS);
  localparam int C_PROD_W = WIDTH_DATA + WIDTH_COEF;
  localparam logic [C_ADDR_W-1:0] C_LAST_TAP = C_ADDR_W'(N_TAPS - 1);
  localparam logic [C_ADDR_W-1:0] C_TAP_ONE  = C_ADDR_W'(1);
  localparam logic signed [WIDTH_ACC-1:0] C_SAT_MAX = WIDTH_ACC'((2 ** (WIDTH_OUT - 1)) - 1);
  // Bitwise inverse of the positive limit is the negative limit in two's complement
  localparam logic signed [WIDTH_ACC-1:0] C_SAT_MIN = ~C_SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_SHIFT = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [C_ADDR_W-1:0]          tap_q, tap_d;
  logic signed [WIDTH_ACC-1:0]  acc_q, acc_d;
  logic [WIDTH_DATA-1:0]        samp_q, samp_d;
  logic [WIDTH_OUT-1:0]         out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;

  logic signed [C_PROD_W-1:0]   w_q_ext;
  logic signed [C_PROD_W-1:0]   w_c_ext;
  logic signed [C_PROD_W-1:0]   w_prod;
  logic signed [WIDTH_ACC-1:0]  w_prod_ext;
  logic signed [WIDTH_ACC-1:0]  w_shifted;
  logic [WIDTH_OUT-1:0]         w_sat;

  // Full-precision signed product of the addressed tap and coefficient
  always_comb begin
    w_q_ext    = {{WIDTH_COEF{asr_q[WIDTH_DATA-1]}}, asr_q};
    w_c_ext    = {{WIDTH_DATA{coef[WIDTH_COEF-1]}}, coef};
    w_prod     = w_q_ext * w_c_ext;
    w_prod_ext = {{(WIDTH_ACC - C_PROD_W){w_prod[C_PROD_W-1]}}, w_prod};
  end

  // Floor-scale the accumulator and clamp it to the output range
  always_comb begin
    w_shifted = acc_q >>> OUT_SHIFT;
    if (w_shifted > C_SAT_MAX) begin
      w_sat = C_SAT_MAX[WIDTH_OUT-1:0];
    end else if (w_shifted < C_SAT_MIN) begin
      w_sat = C_SAT_MIN[WIDTH_OUT-1:0];
    end else begin
      w_sat = w_shifted[WIDTH_OUT-1:0];
    end
  end

  // State and datapath registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      samp_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      samp_q      <= samp_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update for the accept / MAC / shift / output cycle
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    samp_d      = samp_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          samp_d  = in_data;
          acc_d   = '0;
          tap_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + w_prod_ext;
        tap_d = tap_q + C_TAP_ONE;
        if (tap_q == C_LAST_TAP) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        out_data_d  = w_sat;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Port drive; clr masks the handshake and the shift pulse in the clear cycle
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !clr;
    asr_en    = (state_q == S_SHIFT) && !clr;
    asr_clr   = clr;
    asr_d     = samp_q;
    asr_add   = (state_q == S_MAC) ? tap_q : '0;
    coef_add  = (state_q == S_MAC) ? tap_q : '0;
    out_valid = out_valid_q;
    out_data  = out_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fir_tap_sequencer                                         |
// | Description : Self-checking bench for fir_tap_sequencer with delay-line    |
// |               and ROM models, a reference FIR model and a scoreboard.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fir_tap_sequencer;

  localparam int N = 16;
  localparam int SHIFT = 7;

  typedef struct {
    int din;
    int exp;
    bit has_exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr, in_valid, in_ready, asr_clr, asr_en, out_valid, out_ready;
  logic [7:0] in_data, asr_d, asr_q, coef, out_data;
  logic [3:0] asr_add, coef_add;

  logic [7:0] line [N];
  int rom  [N];
  int hist [N];
  int exp_q[$];
  int got[$];
  vec_t vt [49];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_e = 0, last_acc = 0, hs_e = 0, tp_last = -1, tp_count = 0, mon_e = 0;
  bit inflight = 1'b0, prev_ov = 1'b0, tp_mode = 1'b0, bp_check = 1'b0;
  logic [7:0] prev_od = '0;

  fir_tap_sequencer dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .asr_clr   (asr_clr),
    .asr_en    (asr_en),
    .asr_add   (asr_add),
    .asr_d     (asr_d),
    .asr_q     (asr_q),
    .coef_add  (coef_add),
    .coef      (coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Delay line: address 0 reads d, address k reads register k-1
  always @(posedge clk) begin
    if (asr_clr) begin
      for (int i = 0; i < N; i++) line[i] <= '0;
    end else if (asr_en) begin
      line[0] <= asr_d;
      for (int i = 1; i < N; i++) line[i] <= line[i-1];
    end
  end

  always_comb begin
    asr_q = (asr_add == 4'd0) ? asr_d : line[asr_add - 4'd1];
    coef  = 8'(rom[coef_add]);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model();
    longint s;
    longint r;
    s = 0;
    for (int k = 0; k < N; k++) s += longint'(hist[k]) * longint'(rom[k]);
    r = s >>> SHIFT;
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    return int'(r);
  endfunction

  // Monitor: protocol checks, address sweep, reference model and scoreboard
  always @(negedge clk) begin
    if (!tp_mode) tp_last = -1;
    if (clr) begin
      exp_q.delete();
      inflight = 1'b0;
      prev_ov  = 1'b0;
      for (int k = 0; k < N; k++) hist[k] = 0;
    end else begin
      if (inflight && (cyc - acc_e) < N) begin
        chk("asr_add_sweep", int'(asr_add), cyc - acc_e);
        chk("coef_add_sweep", int'(coef_add), cyc - acc_e);
        if (asr_en) chk("en_in_mac", 1, 0);
      end else if (inflight && (cyc - acc_e) == N) begin
        chk("shift_en", int'(asr_en), 1);
        inflight = 1'b0;
      end else if (asr_en) begin
        chk("en_spurious", 1, 0);
      end
      if (asr_en && out_valid) chk("en_with_ov", 1, 0);
      if (out_valid) begin
        chk("in_ready_in_out", int'(in_ready), 0);
        if (!prev_ov) chk("ov_latency", cyc - last_acc, N + 1);
        else chk("out_stable", int'(out_data), int'(prev_od));
        if (out_ready) begin
          if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
          else chk("sb_out", int'($signed(out_data)), exp_q.pop_front());
          got.push_back(int'($signed(out_data)));
          hs_e = cyc + 1;
        end
      end
      if (in_valid && in_ready) begin
        mon_e = cyc + 1;
        if (tp_mode) begin
          if (tp_last >= 0) chk("tp_spacing", mon_e - tp_last, N + 3);
          tp_last = mon_e;
          tp_count++;
        end
        if (bp_check) chk("bp_accept_gap", mon_e - hs_e, 1);
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'($signed(in_data));
        exp_q.push_back(model());
        acc_e    = mon_e;
        last_acc = mon_e;
        inflight = 1'b1;
      end
      prev_ov = out_valid;
      prev_od = out_data;
    end
  end

  task automatic send(input int x);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'(x);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic run_vecs(input string tag, input int first, input int count);
    int base;
    base = got.size();
    for (int i = 0; i < count; i++) send(vt[first+i].din);
    drain();
    chk({tag, "_count"}, got.size() - base, count);
    for (int i = 0; i < count; i++) begin
      if (vt[first+i].has_exp && (base + i) < got.size())
        chk(tag, got[base+i], vt[first+i].exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int held;
    // Vector table: impulse (0..16), saturation positive (17..32), negative (33..48)
    for (int i = 0; i < 17; i++) begin
      vt[i].din     = (i == 0) ? 64 : 0;
      vt[i].exp     = (i < 16) ? i + 1 : 0;
      vt[i].has_exp = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      vt[17+i].din     = 127;
      vt[17+i].exp     = 127;
      vt[17+i].has_exp = (i == 15);
      vt[33+i].din     = -128;
      vt[33+i].exp     = -128;
      vt[33+i].has_exp = (i == 15);
    end

    clr = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < N; k++) rom[k] = 2 * (k + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_asr_clr", int'(asr_clr), 1);
    chk("rst_asr_en", int'(asr_en), 0);
    chk("rst_asr_add", int'(asr_add), 0);
    chk("rst_out_data", int'(out_data), 0);
    clr = 1'b0;
    #1;
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_asr_clr", int'(asr_clr), 0);

    // Impulse response
    run_vecs("impulse", 0, 17);

    // Saturation
    for (int k = 0; k < N; k++) rom[k] = 127;
    run_vecs("sat", 17, 32);

    // Backpressure with mixed-sign coefficients
    for (int k = 0; k < N; k++) rom[k] = 9 * k - 60;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'd20;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("bp_ov_reached", int'(out_valid), 1);
    held = int'(out_data);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_data", int'(out_data), held);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_no_en", int'(asr_en), 0);
    end
    bp_check = 1'b1;
    in_data  = 8'hE2;
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_second_accept", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    bp_check = 1'b0;

    // Throughput with in_valid and out_ready held high
    tp_mode = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (100) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tp_mode  = 1'b0;
    drain();
    chk("tp_accepts", tp_count, 6);

    // Reset in the middle of MAC
    for (int k = 0; k < N; k++) rom[k] = 2 * (k + 1);
    send(50);
    n = 0;
    while (asr_add != 4'd7 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_tap_reached", int'(asr_add), 7);
    clr = 1'b1;
    #1;
    chk("mid_asr_clr", int'(asr_clr), 1);
    chk("mid_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    chk("mid_out_valid", int'(out_valid), 0);
    chk("mid_idle", int'(in_ready), 1);
    chk("mid_asr_add", int'(asr_add), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("mid_no_en", int'(asr_en), 0);
      chk("mid_no_ov", int'(out_valid), 0);
    end
    run_vecs("impulse_after_rst", 0, 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
